// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, state encoding and default coefficients for the phase FIR scheduler
//
// Purpose: default sizing for fir_phase_scheduler, its FSM state encoding and
// the reset value of the per-tap shift table.
// Ports: none (package).

package fir_pkg;

  localparam int DEF_ORDER    = 5;   // filter order, taps 0..ORDER
  localparam int DEF_DATA_LEN = 8;   // unsigned sample width
  localparam int DEF_OUT_LEN  = 16;  // accumulator / result width
  localparam int DEF_NPH      = 3;   // number of phase requesters
  localparam int DEF_SH_W     = 3;   // shift-coefficient width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Reset value of the shift table: tap i is attenuated by 2^i.
  function automatic int default_shift(input int tap);
    return tap;
  endfunction

endpackage

// File: rtl/fir_phase_scheduler_rr_arbiter.sv
// rtl/fir_phase_scheduler_rr_arbiter.sv - round-robin arbiter granting the first request after the last served one
//
// Purpose: combinational round-robin grant. The search starts at ptr_i+1
// and wraps, so the requester named by ptr_i has the lowest priority.
// Ports:
//   req_i        in   N      request vector
//   ptr_i        in   IDX_W  index of the last served requester
//   grant_o      out  N      one-hot grant (all zero when no request)
//   grant_idx_o  out  IDX_W  binary index of the granted requester
//   any_o        out  1      at least one request is granted

module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  always_comb begin
    int  idx;
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
        found        = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/fir_phase_scheduler.sv
// rtl/fir_phase_scheduler.sv - one shift-and-add FIR tap unit shared round-robin across phase sample streams
//
// Purpose: accepts one sample at a time from NPH phase streams, shifts it into
// that phase's tap history, accumulates one tap per cycle and returns a
// phase-tagged result. Holds the programmable per-tap right-shift table.
// Ports:
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous active-high reset
//   in_valid   in   NPH           per-phase sample valid
//   in_data    in   NPH*DATA_LEN  phase p at [p*DATA_LEN +: DATA_LEN]
//   in_ready   out  NPH           one-hot grant, only while idle
//   cfg_we     in   1             shift-table write strobe (idle only)
//   cfg_addr   in   3             tap index (> ORDER ignored)
//   cfg_shift  in   SH_W          right-shift amount for that tap
//   out_valid  out  1             result valid
//   out_ready  in   1             downstream accepts result
//   out_phase  out  2             phase of the result
//   out_data   out  OUT_LEN       filter result
//   busy       out  1             a sample is in flight

module fir_phase_scheduler
  import fir_pkg::*;
#(
  parameter int ORDER    = DEF_ORDER,
  parameter int DATA_LEN = DEF_DATA_LEN,
  parameter int OUT_LEN  = DEF_OUT_LEN,
  parameter int NPH      = DEF_NPH,
  parameter int SH_W     = DEF_SH_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPH-1:0]          in_valid,
  input  logic [NPH*DATA_LEN-1:0] in_data,
  output logic [NPH-1:0]          in_ready,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic [SH_W-1:0]         cfg_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_phase,
  output logic [OUT_LEN-1:0]      out_data,
  output logic                    busy
);

  localparam int TAP_W = $clog2(ORDER + 1);

  state_e               state_q, state_d;
  logic [1:0]           ptr_q;
  logic [1:0]           phase_q;
  logic [DATA_LEN-1:0]  sample_q;
  logic [TAP_W-1:0]     tap_q;
  logic [OUT_LEN-1:0]   acc_q;
  logic [DATA_LEN-1:0]  hist_q  [NPH][ORDER+1];
  logic [SH_W-1:0]      shift_q [ORDER+1];
  logic                 out_valid_q;
  logic [OUT_LEN-1:0]   out_data_q;
  logic [1:0]           out_phase_q;

  logic [NPH-1:0]       grant;
  logic [1:0]           grant_idx;
  logic                 grant_any;
  logic                 accept;
  logic                 out_fire;
  logic                 last_tap;
  logic                 cfg_hit;
  logic [DATA_LEN-1:0]  tap_sample;
  logic [SH_W-1:0]      tap_shift;
  logic [DATA_LEN-1:0]  term;

  rr_arbiter #(
    .N     (NPH),
    .IDX_W (2)
  ) u_arb (
    .req_i       (in_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  assign accept   = (state_q == ST_IDLE) && grant_any && !rst;
  assign out_fire = out_valid_q && out_ready;
  assign last_tap = (tap_q == TAP_W'(ORDER));
  assign cfg_hit  = cfg_we && (state_q == ST_IDLE) && (int'(cfg_addr) <= ORDER);

  // Current tap contribution; shifting a full sample away gives zero.
  always_comb begin
    tap_sample = hist_q[phase_q][tap_q];
    tap_shift  = shift_q[tap_q];
    if (int'(tap_shift) >= DATA_LEN) begin
      term = '0;
    end else begin
      term = tap_sample >> tap_shift;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)   state_d = ST_LOAD;
      ST_LOAD:                state_d = ST_ACCUM;
      ST_ACCUM: if (last_tap) state_d = ST_OUT;
      ST_OUT:   if (out_fire) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. in_ready is masked during reset so nothing looks granted.
  always_comb begin
    in_ready  = (state_q == ST_IDLE && !rst) ? grant : '0;
    busy      = (state_q != ST_IDLE);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_phase = out_phase_q;
  end

  // Datapath: capture, history, accumulator, coefficient table, result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 2'(NPH - 1);   // phase 0 is searched first after reset
      phase_q     <= '0;
      sample_q    <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_phase_q <= '0;
      for (int p = 0; p < NPH; p++) begin
        for (int t = 0; t <= ORDER; t++) begin
          hist_q[p][t] <= '0;
        end
      end
      for (int t = 0; t <= ORDER; t++) begin
        shift_q[t] <= SH_W'(default_shift(t));
      end
    end else begin
      if (accept) begin
        sample_q <= in_data[int'(grant_idx)*DATA_LEN +: DATA_LEN];
        phase_q  <= grant_idx;
      end

      // A write in the accept cycle lands before ACCUM and so applies to that sample.
      if (cfg_hit) begin
        shift_q[cfg_addr] <= cfg_shift;
      end

      case (state_q)
        ST_LOAD: begin
          for (int t = ORDER; t >= 1; t--) begin
            hist_q[phase_q][t] <= hist_q[phase_q][t-1];
          end
          hist_q[phase_q][0] <= sample_q;
          acc_q <= '0;
          tap_q <= '0;
        end
        ST_ACCUM: begin
          acc_q <= acc_q + OUT_LEN'(term);
          tap_q <= tap_q + 1'b1;
        end
        ST_OUT: begin
          // First OUT cycle registers the result; it then holds until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_q;
            out_phase_q <= phase_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            ptr_q       <= phase_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
